// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC select and the IF/ID pipeline register.
// Define FETCH_CHECK_EN to enable fetch-address checking with a sticky fault and HALT state.
module fetch_stage #(
    parameter int          A_length = 12,
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic [1:0]          pcsrc,
    input  logic [31:0]         branch_target,
    input  logic [31:0]         jalr_target,
    output logic [A_length-1:0] A,
    input  logic [31:0]         RDi,
    output logic [31:0]         pc_f,
    output logic [31:0]         instr_d,
    output logic [31:0]         pc_d,
    output logic [31:0]         pcplus4_d,
    output logic                valid_d,
    output logic                fetch_fault
);

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        trap;
    logic        redirect;
    logic        pc_load;
    logic        bad_pc;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;

    assign A = pc_f[A_length-1:0];

    always_comb begin
        pc_plus4 = pc_f + 32'd4;
        case (pcsrc)
            2'b01:   next_pc = branch_target;
            2'b10:   next_pc = {jalr_target[31:1], 1'b0};
            default: next_pc = pc_plus4;
        endcase
    end

    // A redirect must take effect even while the pipeline is stalled.
    assign redirect = (pcsrc == 2'b01) || (pcsrc == 2'b10);
    assign pc_load  = redirect || !stall;

`ifdef FETCH_CHECK_EN
    logic [31:0] pc_offset;
    logic        fault_q;

    // Unsigned offset from the ROM base catches addresses on either side of the window.
    assign pc_offset   = next_pc - RESET_PC;
    assign bad_pc      = (next_pc[1:0] != 2'b00) || ((pc_offset >> A_length) != 32'd0);
    assign fetch_fault = fault_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fault_q <= 1'b0;
        end else if (trap) begin
            fault_q <= 1'b1;
        end
    end
`else
    assign bad_pc      = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        trap       = 1'b0;
        case (state)
            RUN: begin
                if (pc_load && bad_pc) begin
                    state_next = HALT;
                    trap       = 1'b1;
                end
            end
            HALT:    state_next = HALT;
            default: state_next = RUN;
        endcase
    end

    // In HALT nothing is written, so the bubble loaded on entry stays visible.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_f      <= RESET_PC;
            instr_d   <= NOP;
            pc_d      <= 32'd0;
            pcplus4_d <= 32'd0;
            valid_d   <= 1'b0;
        end else if (state == RUN) begin
            if (trap) begin
                instr_d   <= NOP;
                pc_d      <= 32'd0;
                pcplus4_d <= 32'd0;
                valid_d   <= 1'b0;
            end else begin
                if (pc_load) begin
                    pc_f <= next_pc;
                end
                if (flush) begin
                    instr_d   <= NOP;
                    pc_d      <= 32'd0;
                    pcplus4_d <= 32'd0;
                    valid_d   <= 1'b0;
                end else if (!stall) begin
                    instr_d   <= RDi;
                    pc_d      <= pc_f;
                    pcplus4_d <= pc_plus4;
                    valid_d   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a synthetic instruction ROM.
// Covers reset, sequential fetch, stall, flush, redirects, address wrap and reset-during-redirect.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [1:0]  pcsrc;
    logic [31:0] branchTarget;
    logic [31:0] jalrTarget;
    logic [11:0] addr;
    logic [31:0] rdi;
    logic [31:0] pcF;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic [31:0] pcPlus4D;
    logic        validD;
    logic        fetchFault;

    int assertCount = 0;
    int failCount   = 0;

    fetch_stage #(
        .A_length(12),
        .RESET_PC(32'hBFC00000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .pcsrc        (pcsrc),
        .branch_target(branchTarget),
        .jalr_target  (jalrTarget),
        .A            (addr),
        .RDi          (rdi),
        .pc_f         (pcF),
        .instr_d      (instrD),
        .pc_d         (pcD),
        .pcplus4_d    (pcPlus4D),
        .valid_d      (validD),
        .fetch_fault  (fetchFault)
    );

    function automatic logic [31:0] romWord(input logic [11:0] a);
        return 32'h1000_0000 | {20'd0, a};
    endfunction

    assign rdi = romWord(addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic s, input logic f,
                                 input logic [1:0] src, input logic [31:0] bt,
                                 input logic [31:0] jt);
        rst          = r;
        stall        = s;
        flush        = f;
        pcsrc        = src;
        branchTarget = bt;
        jalrTarget   = jt;
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        tick();
        tick();
        checkOutput("reset_pc_f", pcF, 32'hBFC00000);
        checkOutput("reset_A", {20'd0, addr}, 32'h000);
        checkOutput("reset_instr_d", instrD, 32'h00000013);
        checkOutput("reset_pc_d", pcD, 32'd0);
        checkOutput("reset_pcplus4_d", pcPlus4D, 32'd0);
        checkOutput("reset_valid_d", {31'd0, validD}, 32'd0);
        checkOutput("reset_fault", {31'd0, fetchFault}, 32'd0);

        // First words after reset release
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        tick();
        checkOutput("c1_instr_d", instrD, 32'h1000_0000);
        checkOutput("c1_pc_d", pcD, 32'hBFC00000);
        checkOutput("c1_pcplus4_d", pcPlus4D, 32'hBFC00004);
        checkOutput("c1_valid_d", {31'd0, validD}, 32'd1);
        checkOutput("c1_pc_f", pcF, 32'hBFC00004);
        tick();
        checkOutput("c2_instr_d", instrD, 32'h1000_0004);
        checkOutput("c2_pc_d", pcD, 32'hBFC00004);
        checkOutput("c2_pc_f", pcF, 32'hBFC00008);
        tick();
        tick();
        checkOutput("c4_pc_f", pcF, 32'hBFC00010);
        checkOutput("c4_pc_d", pcD, 32'hBFC0000C);

        // Three-cycle stall at 0xBFC00010
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("stall_pc_f", pcF, 32'hBFC00010);
            checkOutput("stall_pc_d", pcD, 32'hBFC0000C);
            checkOutput("stall_instr_d", instrD, 32'h1000_000C);
            checkOutput("stall_valid_d", {31'd0, validD}, 32'd1);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        tick();
        checkOutput("unstall_instr_d", instrD, 32'h1000_0010);
        checkOutput("unstall_pc_d", pcD, 32'hBFC00010);
        checkOutput("unstall_pc_f", pcF, 32'hBFC00014);

        // Branch with flush and stall together
        applyStimulus(1'b1, 1'b1, 1'b1, 2'b01, 32'hBFC00040, 32'd0);
        tick();
        checkOutput("brflush_pc_f", pcF, 32'hBFC00040);
        checkOutput("brflush_instr_d", instrD, 32'h00000013);
        checkOutput("brflush_pc_d", pcD, 32'd0);
        checkOutput("brflush_valid_d", {31'd0, validD}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        tick();
        checkOutput("brnext_pc_d", pcD, 32'hBFC00040);
        checkOutput("brnext_instr_d", instrD, 32'h1000_0040);
        checkOutput("brnext_valid_d", {31'd0, validD}, 32'd1);
        checkOutput("brnext_pc_f", pcF, 32'hBFC00044);

        // Flush during a stall with no redirect keeps the PC
        applyStimulus(1'b1, 1'b1, 1'b1, 2'b00, 32'd0, 32'd0);
        tick();
        checkOutput("flushstall_pc_f", pcF, 32'hBFC00044);
        checkOutput("flushstall_valid_d", {31'd0, validD}, 32'd0);
        checkOutput("flushstall_pcplus4_d", pcPlus4D, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        tick();
        checkOutput("flushnext_pc_d", pcD, 32'hBFC00044);
        checkOutput("flushnext_pc_f", pcF, 32'hBFC00048);

        // pcsrc=11 behaves as sequential fetch
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b11, 32'hBFC00800, 32'hBFC00900);
        tick();
        checkOutput("src11_pc_f", pcF, 32'hBFC0004C);
        checkOutput("src11_pc_d", pcD, 32'hBFC00048);

        // JALR clears bit 0
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b10, 32'hBFC00800, 32'hBFC00021);
        tick();
        checkOutput("jalr_pc_f", pcF, 32'hBFC00020);
        checkOutput("jalr_A", {20'd0, addr}, 32'h020);
        checkOutput("jalr_pc_d", pcD, 32'hBFC0004C);

        // Redirect overrides stall; IF/ID holds
        applyStimulus(1'b1, 1'b1, 1'b0, 2'b01, 32'hBFC00100, 32'd0);
        tick();
        checkOutput("redirstall_pc_f", pcF, 32'hBFC00100);
        checkOutput("redirstall_pc_d", pcD, 32'hBFC0004C);
        checkOutput("redirstall_valid_d", {31'd0, validD}, 32'd1);

`ifdef FETCH_CHECK_EN
        // Misaligned JALR target traps into HALT
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b10, 32'd0, 32'hBFC00022);
        tick();
        checkOutput("trap_fault", {31'd0, fetchFault}, 32'd1);
        checkOutput("trap_valid_d", {31'd0, validD}, 32'd0);
        checkOutput("trap_pc_f", pcF, 32'hBFC00100);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        tick();
        tick();
        checkOutput("halt_pc_f", pcF, 32'hBFC00100);
        checkOutput("halt_fault", {31'd0, fetchFault}, 32'd1);
        checkOutput("halt_valid_d", {31'd0, validD}, 32'd0);
`else
        // Stepping past the ROM window wraps A without faulting
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b01, 32'hBFC00FFC, 32'd0);
        tick();
        checkOutput("wrap0_pc_f", pcF, 32'hBFC00FFC);
        checkOutput("wrap0_A", {20'd0, addr}, 32'hFFC);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        tick();
        checkOutput("wrap_pc_f", pcF, 32'hBFC01000);
        checkOutput("wrap_A", {20'd0, addr}, 32'h000);
        checkOutput("wrap_fault", {31'd0, fetchFault}, 32'd0);
        checkOutput("wrap_instr_d", instrD, 32'h1000_0FFC);
        checkOutput("wrap_pcplus4_d", pcPlus4D, 32'hBFC01000);
`endif

        // Reset asserted during a stalled redirect
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b01, 32'hBFC00200, 32'd0);
        tick();
        checkOutput("rstredir_pc_f", pcF, 32'hBFC00000);
        checkOutput("rstredir_valid_d", {31'd0, validD}, 32'd0);
        checkOutput("rstredir_instr_d", instrD, 32'h00000013);
        checkOutput("rstredir_fault", {31'd0, fetchFault}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
        tick();
        checkOutput("rerun_instr_d", instrD, 32'h1000_0000);
        checkOutput("rerun_pc_d", pcD, 32'hBFC00000);
        checkOutput("rerun_valid_d", {31'd0, validD}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter A_length, default 12, meaning instruction-memory byte-address width.
REQ-002 The block SHALL have parameter RESET_PC, default 32'hBFC00000, meaning first fetch address after reset.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port stall  input  1  hold PC and IF/ID register.
REQ-006 The block SHALL have port flush  input  1  replace IF/ID contents with a bubble.
REQ-007 The block SHALL have port pcsrc  input  2  next-PC select: 00 PC+4, 01 branch_target, 10 jalr_target, 11 treated as 00.
REQ-008 The block SHALL have port branch_target  input  32  branch/JAL target.
REQ-009 The block SHALL have port jalr_target  input  32  JALR target; bit 0 cleared before use.
REQ-010 The block SHALL have port A  output  A_length  byte address to instruction memory, equal to pc_f[A_length-1:0].
REQ-011 The block SHALL have port RDi  input  32  instruction word from instruction memory, combinational on A.
REQ-012 The block SHALL have port pc_f  output  32  current fetch PC.
REQ-013 The block SHALL have ports instr_d, pc_d, pcplus4_d  output  32 each  IF/ID register contents.
REQ-014 The block SHALL have port valid_d  output  1  IF/ID holds a real instruction.
REQ-015 The block SHALL have port fetch_fault  output  1  sticky fetch-address fault.

Function
REQ-016 Next PC SHALL be pc_f+4, branch_target or jalr_target&~1 per pcsrc, with 32-bit modulo addition.
REQ-017 States SHALL be RUN and HALT; HALT is reachable only per REQ-028.
REQ-018 In RUN with stall=0, flush=0, pcsrc=00 each clock SHALL load pc_f<=next PC and IF/ID<={RDi, pc_f, pc_f+4, valid=1}.
REQ-019 Fetch latency SHALL be one cycle: the word at pc_f appears on instr_d the following cycle.
REQ-020 stall=1 with pcsrc=00, flush=0 SHALL hold pc_f and all IF/ID outputs unchanged.
REQ-021 pcsrc!=00 SHALL override stall: pc_f loads the target the same edge.
REQ-022 flush=1 SHALL override stall and load the bubble: instr_d=32'h00000013, pc_d=0, pcplus4_d=0, valid_d=0.
REQ-023 flush=1 with pcsrc!=00 SHALL redirect pc_f and insert the bubble on the same edge.
REQ-024 Address wrap: A SHALL take only low A_length bits of pc_f; pc_f 0xBFC00FFC +4 gives 0xBFC01000 and A=0x000.
REQ-025 In HALT pc_f, IF/ID outputs and state SHALL stay frozen, with valid_d=0, until reset.

Reset
REQ-026 rst=0 at a rising edge SHALL set pc_f=RESET_PC, state RUN, the REQ-022 bubble, and fetch_fault=0, overriding all other inputs including mid-stall or mid-redirect.
REQ-027 The first edge after rst returns to 1 SHALL capture the word at RESET_PC with valid_d=1, unless stalled or flushed.

Configuration
REQ-028 With macro FETCH_CHECK_EN defined, a next PC with bits[1:0]!=0 or outside RESET_PC..RESET_PC+2**A_length-1 SHALL not be loaded. Instead the block enters HALT, sets fetch_fault=1 and loads the bubble.
REQ-029 Without FETCH_CHECK_EN, fetch_fault SHALL be tied 0, HALT SHALL be unreachable, and any next PC SHALL be loaded as-is.

Verification
REQ-030 Reset release, ROM words W0,W1 at 0x000/0x004 -> cycle 1 instr_d=W0, pc_d=0xBFC00000, pcplus4_d=0xBFC00004, valid_d=1. Cycle 2 instr_d=W1, pc_d=0xBFC00004.
REQ-031 stall=1 for 3 cycles at pc_f=0xBFC00010 -> pc_f and IF/ID unchanged for 3 cycles; the next edge after release captures the word at 0x010.
REQ-032 pcsrc=01, branch_target=0xBFC00040, flush=1, stall=1 -> next cycle pc_f=0xBFC00040, instr_d=0x00000013, valid_d=0. The following cycle pc_d=0xBFC00040, valid_d=1.
REQ-033 pcsrc=10, jalr_target=0xBFC00021 -> pc_f=0xBFC00020. With FETCH_CHECK_EN and target 0xBFC00022 -> fetch_fault=1, valid_d=0, pc_f held, until rst=0.
REQ-034 Without FETCH_CHECK_EN, pc_f=0xBFC00FFC advancing -> pc_f=0xBFC01000, A=0x000, fetch_fault=0. rst=0 during a redirect -> pc_f=0xBFC00000, valid_d=0.
